// File: rtl/complex_mul_tdm.sv
// Time-multiplexed complex multiplier: c = a * b using one signed
// WIDTH x WIDTH multiplier shared over four CALC steps.
// Flow: IDLE (accept operands) -> CALC (4 steps) -> DONE (hold result until taken).
module complex_mul_tdm #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_real_i,
  input  logic [WIDTH-1:0]   a_imag_i,
  input  logic [WIDTH-1:0]   b_real_i,
  input  logic [WIDTH-1:0]   b_imag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH:0]   c_real_o,
  output logic [2*WIDTH:0]   c_imag_o,
  output logic               busy_o,
  output logic [15:0]        op_cnt_o
);

  localparam int PW = 2 * WIDTH;      // raw product width
  localparam int RW = 2 * WIDTH + 1;  // accumulator width, one guard bit

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              step_q;
  logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
  logic signed [WIDTH-1:0] mul_a, mul_b;
  logic signed [PW-1:0]    prod;
  logic signed [RW-1:0]    prod_x;
  logic signed [RW-1:0]    re_acc_q, im_acc_q;
  logic signed [RW-1:0]    im_sum;
  logic [RW-1:0]           c_real_q, c_imag_q;
  logic [15:0]             op_cnt_q;

  // Operand select for the shared multiplier, one pairing per step
  always_comb begin
    mul_a = ar_q;
    mul_b = br_q;
    case (step_q)
      2'd0: begin mul_a = ar_q; mul_b = br_q; end
      2'd1: begin mul_a = ai_q; mul_b = bi_q; end
      2'd2: begin mul_a = ai_q; mul_b = br_q; end
      default: begin mul_a = ar_q; mul_b = bi_q; end
    endcase
  end

  // The single multiplier; product is sign-extended by one bit so the
  // add/sub below can never overflow.
  always_comb begin
    prod   = PW'(mul_a) * PW'(mul_b);
    prod_x = {prod[PW-1], prod};
    im_sum = im_acc_q + prod_x;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)       state_d = CALC;
      CALC:    if (step_q == 2'd3)   state_d = DONE;
      DONE:    if (out_ready_i)      state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operand capture, step sequencing, accumulation and result/counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      step_q   <= 2'd0;
      ar_q     <= '0;
      ai_q     <= '0;
      br_q     <= '0;
      bi_q     <= '0;
      re_acc_q <= '0;
      im_acc_q <= '0;
      c_real_q <= '0;
      c_imag_q <= '0;
      op_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            ar_q   <= a_real_i;
            ai_q   <= a_imag_i;
            br_q   <= b_real_i;
            bi_q   <= b_imag_i;
            step_q <= 2'd0;
          end
        end
        CALC: begin
          step_q <= step_q + 2'd1;
          case (step_q)
            2'd0: re_acc_q <= prod_x;
            2'd1: re_acc_q <= re_acc_q - prod_x;
            2'd2: im_acc_q <= prod_x;
            default: begin
              im_acc_q <= im_sum;
              // Results live in their own registers so they survive the
              // accumulators being reused by the next operation.
              c_real_q <= re_acc_q;
              c_imag_q <= im_sum;
            end
          endcase
        end
        DONE: begin
          if (out_ready_i) op_cnt_q <= op_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign c_real_o    = c_real_q;
  assign c_imag_o    = c_imag_q;
  assign op_cnt_o    = op_cnt_q;

endmodule

// File: tb/tb_complex_mul_tdm.sv
// Directed bench for complex_mul_tdm (WIDTH=8). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_complex_mul_tdm;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  a_real_i, a_imag_i, b_real_i, b_imag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [16:0] c_real_o, c_imag_o;
  logic        busy_o;
  logic [15:0] op_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  complex_mul_tdm #(.WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_real_i    (a_real_i),
    .a_imag_i    (a_imag_i),
    .b_real_i    (b_real_i),
    .b_imag_i    (b_imag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .c_real_o    (c_real_o),
    .c_imag_o    (c_imag_o),
    .busy_o      (busy_o),
    .op_cnt_o    (op_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_ops(input int ar, input int ai, input int br, input int bi);
    a_real_i = 8'(ar);
    a_imag_i = 8'(ai);
    b_real_i = 8'(br);
    b_imag_i = 8'(bi);
  endtask

  // One full operation with out_ready_i=1 and hand-computed result.
  task automatic run_op(input string tag, input int ar, input int ai, input int br,
                        input int bi, input int er, input int ei);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    set_ops(ar, ai, br, bi);
    tick();                                     // accepting edge
    in_valid_i = 1'b0;
    set_ops(11, -13, 17, -19);                  // must be ignored
    chk({tag, "_busy"}, busy_o, 1);
    chk({tag, "_rdy_calc"}, in_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_vld_early"}, out_valid_o, 0);
      tick();
    end
    chk({tag, "_vld_early"}, out_valid_o, 0);
    tick();                                     // 4th edge after accept
    chk({tag, "_vld"}, out_valid_o, 1);
    chk({tag, "_re"}, $signed(c_real_o), er);
    chk({tag, "_im"}, $signed(c_imag_o), ei);
    tick();                                     // handshake
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    chk({tag, "_cnt"}, op_cnt_o, exp_cnt);
    chk({tag, "_vld_off"}, out_valid_o, 0);
    chk({tag, "_rdy_back"}, in_ready_o, 1);
    chk({tag, "_re_keep"}, $signed(c_real_o), er);
    chk({tag, "_im_keep"}, $signed(c_imag_o), ei);
  endtask

  // Per-slot table for the back-to-back test
  int tv_ar [3] = '{-7, 100, 1};
  int tv_ai [3] = '{2, -50, 1};
  int tv_br [3] = '{3, -20, 1};
  int tv_bi [3] = '{5, 10, 1};
  int tv_er [3] = '{-31, -1500, 0};
  int tv_ei [3] = '{-29, 2000, 2};

  initial begin
    longint hold_re, hold_im;
    rst_n_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    set_ops(0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Reset state
    chk("rst_rdy", in_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_vld", out_valid_o, 0);
    chk("rst_re", c_real_o, 0);
    chk("rst_im", c_imag_o, 0);
    chk("rst_cnt", op_cnt_o, 0);

    // Basic product and extreme operands
    run_op("basic", 3, 4, 5, -2, 23, 14);
    run_op("minmin", -128, -128, -128, -128, 0, 32768);
    // (-128+127j)(-128-128j): re = 16384+16256, im = -16256+16384
    run_op("minmax", -128, 127, -128, -128, 32640, 128);

    // Backpressure in DONE
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    set_ops(6, -3, -4, 9);   // re = -24+27 = 3, im = 12+54 = 66
    tick();
    in_valid_i = 1'b0;
    repeat (4) tick();
    chk("bp_vld", out_valid_o, 1);
    chk("bp_re", $signed(c_real_o), 3);
    chk("bp_im", $signed(c_imag_o), 66);
    hold_re = $signed(c_real_o);
    hold_im = $signed(c_imag_o);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = i[0];
      set_ops(i * 7, -i, 50 - i, i + 3);
      tick();
      chk("bp_hold_vld", out_valid_o, 1);
      chk("bp_hold_rdy", in_ready_o, 0);
      chk("bp_hold_re", $signed(c_real_o), hold_re);
      chk("bp_hold_im", $signed(c_imag_o), hold_im);
      chk("bp_hold_cnt", op_cnt_o, exp_cnt);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    exp_cnt++;
    chk("bp_cnt", op_cnt_o, exp_cnt);
    chk("bp_vld_off", out_valid_o, 0);
    chk("bp_re_keep", $signed(c_real_o), 3);
    tick();
    chk("bp_single", op_cnt_o, exp_cnt);

    // Back-to-back with in_valid_i held high and operands changing every cycle
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      chk("b2b_rdy", in_ready_o, (cyc % 6 == 0) ? 1 : 0);
      chk("b2b_vld", out_valid_o, (cyc % 6 == 5) ? 1 : 0);
      if (cyc % 6 == 5) begin
        chk("b2b_re", $signed(c_real_o), tv_er[cyc / 6]);
        chk("b2b_im", $signed(c_imag_o), tv_ei[cyc / 6]);
      end
      if (cyc % 6 == 0)
        set_ops(tv_ar[cyc / 6], tv_ai[cyc / 6], tv_br[cyc / 6], tv_bi[cyc / 6]);
      else
        set_ops(cyc * 5, -cyc, cyc + 40, -3 * cyc);
      tick();
    end
    in_valid_i = 1'b0;
    exp_cnt += 3;
    chk("b2b_cnt", op_cnt_o, exp_cnt);

    // Reset while CALC step 2 is pending
    in_valid_i = 1'b1;
    set_ops(9, 9, 9, 9);
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();                  // steps 0 and 1 done, step 2 next
    chk("mid_busy_pre", busy_o, 1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_vld", out_valid_o, 0);
    chk("mid_re", c_real_o, 0);
    chk("mid_im", c_imag_o, 0);
    chk("mid_cnt", op_cnt_o, 0);
    exp_cnt = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rdy", in_ready_o, 1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_vld", out_valid_o, 0);
      tick();
    end

    // Counter wrap
    force dut.op_cnt_q = 16'hFFFF;
    #1 release dut.op_cnt_q;
    chk("wrap_pre", op_cnt_o, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    run_op("wrap", 2, 0, 3, 0, 6, 0);
    chk("wrap_zero", op_cnt_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
